// File: rtl/quadrature_decoder_mc.sv
// quadrature_decoder_mc
// Multi-channel quadrature encoder decoder. For each of NUM_CH channels it provides a
// 2-flop input synchroniser, A/B and Z debouncers, x1/x2/x4 decoding, sticky
// illegal-transition detection, a one-shot Z-mark position preset, and a signed delta
// counter that pulses a trigger every delta_size steps.
//
// Optional feature, enabled by defining QDEC_VELOCITY_EN: a shared window counter and
// per-channel signed step accumulators that publish saturated steps-per-window on
// `velocity` with a one-cycle `velocity_valid` strobe. Without the macro, `velocity`
// and `velocity_valid` are tied to 0 and `vel_window` is ignored.
//
// Ports (bit n / slice n = channel n):
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_a, i_b, i_z        raw encoder inputs
//   enable, clear        per-channel enable and single-cycle clear
//   count_mode           00/11 = x4, 01 = x2, 10 = x1
//   dbnc_time            debounce length in cycles (shared)
//   delta_size           steps per trigger pulse, 0 disables triggers
//   zero_position        per-channel Z preset, POSITION_SIZE bits per channel
//   vel_window           velocity sample period in cycles, 0 stops sampling
//   absolute_position    per-channel position, packed like zero_position
//   direction            direction of last counted step, 1 = forward
//   zero_mark_detected   sticky first-Z flag
//   trigger_out          one-cycle delta trigger pulse
//   quad_error           sticky illegal-transition flag
//   velocity             per-channel signed steps per window, VEL_WIDTH bits each
//   velocity_valid       one-cycle pulse when velocity updates
module quadrature_decoder_mc #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned POSITION_SIZE = 32,
  parameter int unsigned DBNC_WIDTH    = 16,
  parameter int unsigned VEL_WIDTH     = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_CH-1:0]               i_a,
  input  logic [NUM_CH-1:0]               i_b,
  input  logic [NUM_CH-1:0]               i_z,
  input  logic [NUM_CH-1:0]               enable,
  input  logic [NUM_CH-1:0]               clear,
  input  logic [1:0]                      count_mode,
  input  logic [DBNC_WIDTH-1:0]           dbnc_time,
  input  logic [POSITION_SIZE-1:0]        delta_size,
  input  logic [NUM_CH*POSITION_SIZE-1:0] zero_position,
  input  logic [31:0]                     vel_window,
  output logic [NUM_CH*POSITION_SIZE-1:0] absolute_position,
  output logic [NUM_CH-1:0]               direction,
  output logic [NUM_CH-1:0]               zero_mark_detected,
  output logic [NUM_CH-1:0]               trigger_out,
  output logic [NUM_CH-1:0]               quad_error,
  output logic [NUM_CH*VEL_WIDTH-1:0]     velocity,
  output logic                            velocity_valid
);

  localparam logic [POSITION_SIZE-1:0] PosOne  = POSITION_SIZE'(1);
  localparam logic [DBNC_WIDTH-1:0]    DbncOne = DBNC_WIDTH'(1);

  // Trigger thresholds +(delta_size-1) and -(delta_size-1), shared by all channels.
  logic [POSITION_SIZE-1:0] dsz_m1;
  logic [POSITION_SIZE-1:0] dsz_neg;
  logic                     delta_en;

  assign dsz_m1   = delta_size - PosOne;
  assign dsz_neg  = ~dsz_m1 + PosOne;
  assign delta_en = (delta_size != '0);

`ifdef QDEC_VELOCITY_EN
  // Accumulator is wide enough for a full 32-bit window of steps in either direction.
  localparam int unsigned AccW = (VEL_WIDTH > 33) ? VEL_WIDTH + 1 : 34;
  localparam logic signed [AccW-1:0] VelMax = AccW'((64'sd1 <<< (VEL_WIDTH - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0] VelMin = -VelMax;

  logic [31:0] win_q, win_d;
  logic        vel_valid_q, vel_valid_d;
  logic        win_end;

  always_comb begin
    win_end     = (vel_window != 32'd0) && (win_q >= vel_window - 32'd1);
    vel_valid_d = win_end;
    win_d       = win_q;
    if (vel_window != 32'd0) begin
      win_d = win_end ? 32'd0 : win_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign velocity_valid = vel_valid_q;
`else
  logic unused_vel_window;
  assign unused_vel_window = ^vel_window;
  assign velocity          = '0;
  assign velocity_valid    = 1'b0;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    // Sync stages hold {a, b, z}; accepted A/B state is {a, b}.
    logic [2:0]               sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DBNC_WIDTH-1:0]    cnt_ab_q, cnt_ab_d, cnt_z_q, cnt_z_d;
    logic [1:0]               ab_q, ab_d, ab_prev_q, ab_prev_d;
    logic                     z_q, z_d;
    logic                     ev_ab_q, ev_ab_d, ev_z_q, ev_z_d;
    logic [POSITION_SIZE-1:0] pos_q, pos_d, delta_q, delta_d;
    logic                     dir_q, dir_d, zmd_q, zmd_d;
    logic                     trig_q, trig_d, err_q, err_d;
    logic                     a_chg, b_chg, fwd, illegal, mode_ok, step, zload;

    // Decode the event accepted on the previous cycle.
    always_comb begin
      a_chg   = ab_prev_q[1] ^ ab_q[1];
      b_chg   = ab_prev_q[0] ^ ab_q[0];
      fwd     = ab_prev_q[0] ^ ab_q[1];
      illegal = ev_ab_q & a_chg & b_chg;
      unique case (count_mode)
        2'b01:   mode_ok = a_chg;
        2'b10:   mode_ok = ((ab_prev_q == 2'b00) && (ab_q == 2'b10)) ||
                           ((ab_prev_q == 2'b10) && (ab_q == 2'b00));
        default: mode_ok = 1'b1;
      endcase
      step  = enable[ch] & ev_ab_q & ~illegal & mode_ok;
      // An accepted Z event with new value 1 is a rising edge.
      zload = enable[ch] & ev_z_q & z_q & ~zmd_q;
    end

    always_comb begin
      sync1_d   = sync1_q;
      sync2_d   = sync2_q;
      cnt_ab_d  = '0;  // debounce counters are forced to 0 while disabled
      cnt_z_d   = '0;
      ab_d      = ab_q;
      ab_prev_d = ab_prev_q;
      z_d       = z_q;
      ev_ab_d   = ev_ab_q;
      ev_z_d    = ev_z_q;
      pos_d     = pos_q;
      delta_d   = delta_q;
      dir_d     = dir_q;
      zmd_d     = zmd_q;
      err_d     = err_q;
      trig_d    = 1'b0;

      if (enable[ch]) begin
        sync1_d = {i_a[ch], i_b[ch], i_z[ch]};
        sync2_d = sync1_q;
        ev_ab_d = 1'b0;
        ev_z_d  = 1'b0;

        if (sync1_q[2:1] != sync2_q[2:1]) begin
          cnt_ab_d = '0;
        end else if (cnt_ab_q >= dbnc_time) begin
          cnt_ab_d = dbnc_time;
          if ((cnt_ab_q == dbnc_time) && (sync2_q[2:1] != ab_q)) begin
            ab_prev_d = ab_q;
            ab_d      = sync2_q[2:1];
            ev_ab_d   = 1'b1;
          end
        end else begin
          cnt_ab_d = cnt_ab_q + DbncOne;
        end

        if (sync1_q[0] != sync2_q[0]) begin
          cnt_z_d = '0;
        end else if (cnt_z_q >= dbnc_time) begin
          cnt_z_d = dbnc_time;
          if ((cnt_z_q == dbnc_time) && (sync2_q[0] != z_q)) begin
            z_d    = sync2_q[0];
            ev_z_d = 1'b1;
          end
        end else begin
          cnt_z_d = cnt_z_q + DbncOne;
        end

        if (illegal) err_d = 1'b1;
        if (step)    dir_d = fwd;

        // Z load takes priority; the same-cycle step only affects direction/velocity.
        if (zload) begin
          pos_d   = zero_position[ch*POSITION_SIZE +: POSITION_SIZE];
          delta_d = '0;
          zmd_d   = 1'b1;
        end else if (step) begin
          pos_d = fwd ? pos_q + PosOne : pos_q - PosOne;
          if (delta_en && (delta_q == (fwd ? dsz_m1 : dsz_neg))) begin
            delta_d = '0;
            trig_d  = 1'b1;
          end else begin
            delta_d = fwd ? delta_q + PosOne : delta_q - PosOne;
          end
        end
      end

      if (clear[ch]) begin
        pos_d   = '0;
        delta_d = '0;
        err_d   = 1'b0;
        zmd_d   = 1'b0;
        trig_d  = 1'b0;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        sync1_q   <= '0;
        sync2_q   <= '0;
        cnt_ab_q  <= '0;
        cnt_z_q   <= '0;
        ab_q      <= '0;
        ab_prev_q <= '0;
        z_q       <= 1'b0;
        ev_ab_q   <= 1'b0;
        ev_z_q    <= 1'b0;
        pos_q     <= '0;
        delta_q   <= '0;
        dir_q     <= 1'b0;
        zmd_q     <= 1'b0;
        trig_q    <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        cnt_ab_q  <= cnt_ab_d;
        cnt_z_q   <= cnt_z_d;
        ab_q      <= ab_d;
        ab_prev_q <= ab_prev_d;
        z_q       <= z_d;
        ev_ab_q   <= ev_ab_d;
        ev_z_q    <= ev_z_d;
        pos_q     <= pos_d;
        delta_q   <= delta_d;
        dir_q     <= dir_d;
        zmd_q     <= zmd_d;
        trig_q    <= trig_d;
        err_q     <= err_d;
      end
    end

    assign absolute_position[ch*POSITION_SIZE +: POSITION_SIZE] = pos_q;
    assign direction[ch]          = dir_q;
    assign zero_mark_detected[ch] = zmd_q;
    assign trigger_out[ch]        = trig_q;
    assign quad_error[ch]         = err_q;

`ifdef QDEC_VELOCITY_EN
    logic signed [AccW-1:0] acc_q, acc_d, acc_inc;
    logic [VEL_WIDTH-1:0]   vel_q, vel_d;

    // A step in the window-end cycle seeds the new window.
    always_comb begin
      acc_inc = '0;
      if (step) acc_inc = fwd ? AccW'(1) : '1;
      acc_d = acc_q + acc_inc;
      vel_d = vel_q;
      if (win_end) begin
        acc_d = acc_inc;
        if (acc_q > VelMax) begin
          vel_d = VelMax[VEL_WIDTH-1:0];
        end else if (acc_q < VelMin) begin
          vel_d = VelMin[VEL_WIDTH-1:0];
        end else begin
          vel_d = acc_q[VEL_WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        acc_q <= '0;
        vel_q <= '0;
      end else begin
        acc_q <= acc_d;
        vel_q <= vel_d;
      end
    end

    assign velocity[ch*VEL_WIDTH +: VEL_WIDTH] = vel_q;
`endif
  end

endmodule

// File: tb/tb_quadrature_decoder_mc.sv
// Self-checking bench for quadrature_decoder_mc: latency, x4/x2/x1 decoding, illegal
// transitions, glitch rejection, Z preset, delta triggers, enable gating, velocity
// (when QDEC_VELOCITY_EN is defined) and mid-run reset.
module tb_quadrature_decoder_mc;

  localparam int NCH = 4;
  localparam int P   = 32;
  localparam int VW  = 16;
  localparam int NV  = 33;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ra, rb, rz, en, clr;
  logic [1:0]       mode;
  logic [15:0]      dbnc;
  logic [P-1:0]     dsz;
  logic [NCH*P-1:0] zpos;
  logic [31:0]      vwin;
  logic [NCH*P-1:0] absolute_position;
  logic [NCH-1:0]   direction, zero_mark_detected, trigger_out, quad_error;
  logic [NCH*VW-1:0] velocity;
  logic             velocity_valid;

  int checks = 0;
  int errors = 0;
  int trig_total = 0;

  quadrature_decoder_mc #(
    .NUM_CH(NCH), .POSITION_SIZE(P), .DBNC_WIDTH(16), .VEL_WIDTH(VW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_a(ra), .i_b(rb), .i_z(rz),
    .enable(en), .clear(clr), .count_mode(mode), .dbnc_time(dbnc),
    .delta_size(dsz), .zero_position(zpos), .vel_window(vwin),
    .absolute_position(absolute_position), .direction(direction),
    .zero_mark_detected(zero_mark_detected), .trigger_out(trigger_out),
    .quad_error(quad_error), .velocity(velocity), .velocity_valid(velocity_valid)
  );

  always #5 clk = ~clk;

  // Counts cycles in which channel 0 trigger is high.
  always @(negedge clk) if (trigger_out[0]) trig_total <= trig_total + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          clr;
    int          ch;
    bit [1:0]    mode;
    bit          a;
    bit          b;
    int unsigned pos;
    bit          dir;
    bit          err;
  } vec_t;

  vec_t vecs [NV];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [P-1:0] pos_of(input int ch);
    return absolute_position[ch*P +: P];
  endfunction

  task automatic settle();
    tick(int'(dbnc) + 8);
  endtask

  task automatic step_ab(input int ch, input bit a, input bit b);
    ra[ch] = a;
    rb[ch] = b;
    settle();
  endtask

  initial begin
    int  base;
    bit  seen;
    vecs = '{
      '{0, 0, 2'd0, 1, 1, 2, 1, 0}, '{0, 0, 2'd0, 0, 1, 3, 1, 0},
      '{0, 0, 2'd0, 0, 0, 4, 1, 0}, '{0, 0, 2'd0, 1, 0, 5, 1, 0},
      '{0, 0, 2'd0, 1, 1, 6, 1, 0}, '{0, 0, 2'd0, 0, 1, 7, 1, 0},
      '{0, 0, 2'd0, 0, 0, 8, 1, 0},
      '{1, 0, 2'd1, 1, 0, 1, 1, 0}, '{0, 0, 2'd1, 1, 1, 1, 1, 0},
      '{0, 0, 2'd1, 0, 1, 2, 1, 0}, '{0, 0, 2'd1, 0, 0, 2, 1, 0},
      '{0, 0, 2'd1, 1, 0, 3, 1, 0}, '{0, 0, 2'd1, 1, 1, 3, 1, 0},
      '{0, 0, 2'd1, 0, 1, 4, 1, 0}, '{0, 0, 2'd1, 0, 0, 4, 1, 0},
      '{1, 0, 2'd2, 1, 0, 1, 1, 0}, '{0, 0, 2'd2, 1, 1, 1, 1, 0},
      '{0, 0, 2'd2, 0, 1, 1, 1, 0}, '{0, 0, 2'd2, 0, 0, 1, 1, 0},
      '{0, 0, 2'd2, 1, 0, 2, 1, 0}, '{0, 0, 2'd2, 1, 1, 2, 1, 0},
      '{0, 0, 2'd2, 0, 1, 2, 1, 0}, '{0, 0, 2'd2, 0, 0, 2, 1, 0},
      '{0, 0, 2'd2, 0, 1, 2, 1, 0}, '{0, 0, 2'd2, 1, 1, 2, 1, 0},
      '{0, 0, 2'd2, 1, 0, 2, 1, 0}, '{0, 0, 2'd2, 0, 0, 1, 0, 0},
      '{0, 0, 2'd2, 0, 1, 1, 0, 0}, '{0, 0, 2'd2, 1, 1, 1, 0, 0},
      '{0, 0, 2'd2, 1, 0, 1, 0, 0}, '{0, 0, 2'd2, 0, 0, 0, 0, 0},
      '{0, 1, 2'd0, 1, 1, 0, 0, 1}, '{0, 1, 2'd0, 0, 1, 1, 1, 1}
    };

    rst = 1'b1; ra = '0; rb = '0; rz = '0; en = '1; clr = '0;
    mode = 2'b00; dbnc = 16'd3; dsz = '0; zpos = '0; vwin = 32'd100;
    tick(2);
    chk("rst_pos", {63'b0, |absolute_position}, 64'd0);
    chk("rst_flags", {48'b0, direction, zero_mark_detected, trigger_out, quad_error}, 64'd0);
    chk("rst_vel", {62'b0, |velocity, velocity_valid}, 64'd0);
    rst = 1'b0;
    tick(10);

    // Latency: first sampling edge is the first posedge after the drive.
    ra[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 6) chk("lat_edge6", pos_of(0), 64'd0);
    end
    chk("lat_edge7", pos_of(0), 64'd1);
    chk("lat_dir", direction[0], 1'b1);
    settle();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].clr) begin
        clr[vecs[i].ch] = 1'b1;
        tick(1);
        clr = '0;
      end
      mode = vecs[i].mode;
      step_ab(vecs[i].ch, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_pos", i), pos_of(vecs[i].ch), 64'(vecs[i].pos));
      chk($sformatf("vec%0d_dir", i), direction[vecs[i].ch], vecs[i].dir);
      chk($sformatf("vec%0d_err", i), quad_error[vecs[i].ch], vecs[i].err);
    end

    // Glitch of 2 cycles on ch1 A must be rejected.
    ra[1] = 1'b1;
    tick(2);
    ra[1] = 1'b0;
    settle();
    chk("glitch_pos", pos_of(1), 64'd1);

    // Z preset, then delta triggers on ch0.
    mode = 2'b00;
    zpos[P-1:0] = 32'h100;
    rz[0] = 1'b1;
    settle();
    chk("z_pos", pos_of(0), 64'h100);
    chk("z_zmd", zero_mark_detected, 4'b0001);
    dsz = 32'd4;
    base = trig_total;
    step_ab(0, 1, 0);
    step_ab(0, 1, 1);
    step_ab(0, 0, 1);
    chk("trig_none_yet", trig_total - base, 64'd0);
    ra[0] = 1'b0;
    rb[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (trigger_out[0] && !seen) begin
        seen = 1'b1;
        chk("trig_with_pos", pos_of(0), 64'h104);
      end
    end
    chk("trig_seen", seen, 1'b1);
    chk("trig_fwd_count", trig_total - base, 64'd1);
    step_ab(0, 0, 1);
    step_ab(0, 1, 1);
    step_ab(0, 1, 0);
    step_ab(0, 0, 0);
    chk("trig_rev_count", trig_total - base, 64'd2);
    chk("trig_rev_pos", pos_of(0), 64'h100);
    chk("trig_rev_dir", direction[0], 1'b0);

    // A second Z rise is ignored while the mark flag is set.
    rz[0] = 1'b0;
    settle();
    zpos[P-1:0] = 32'h200;
    rz[0] = 1'b1;
    settle();
    chk("z2_ignored", pos_of(0), 64'h100);

    // Changes while disabled are only counted after re-enable.
    en[3] = 1'b0;
    ra[3] = 1'b1;
    settle();
    chk("dis_hold", pos_of(3), 64'd0);
    en[3] = 1'b1;
    settle();
    chk("reen_pos", pos_of(3), 64'd1);
    chk("reen_dir", direction[3], 1'b1);

    // Ten forward steps on ch2 inside one velocity window.
    dbnc = 16'd0;
    tick(4);
`ifdef QDEC_VELOCITY_EN
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1);
      if (velocity_valid) seen = 1'b1;
    end
    chk("vel_first_window", seen, 1'b1);
`endif
    for (int s = 0; s < 10; s++) begin
      ra[2] = (s % 4 == 0 || s % 4 == 1);
      rb[2] = (s % 4 == 1 || s % 4 == 2);
      tick(5);
    end
    tick(4);
    chk("vel_pos", pos_of(2), 64'd10);
    seen = 1'b0;
    for (int k = 0; k < 150 && !seen; k++) begin
      if (velocity_valid) seen = 1'b1;
      else tick(1);
    end
`ifdef QDEC_VELOCITY_EN
    chk("vel_valid", seen, 1'b1);
    chk("vel_ch2", velocity[2*VW +: VW], 64'd10);
    chk("vel_ch0", velocity[0 +: VW], 64'd0);
    tick(1);
    chk("vel_valid_pulse", velocity_valid, 1'b0);
`else
    chk("vel_valid_off", seen, 1'b0);
    chk("vel_tied", {63'b0, |velocity}, 64'd0);
`endif

    // Reset with a pending ch2 edge and a clear request.
    ra[2] = ~ra[2];
    clr[2] = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("mid_rst_pos", {63'b0, |absolute_position}, 64'd0);
    chk("mid_rst_flags", {48'b0, direction, zero_mark_detected, trigger_out, quad_error},
        64'd0);
    chk("mid_rst_vel", {62'b0, |velocity, velocity_valid}, 64'd0);
    rst = 1'b0;
    clr = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
